// File: rtl/copy_read_engine_split.sv
// copy_read_engine_split
// Splits copy read commands into MAX_BURST-aligned read bursts and issues
// them under a lines-in-flight credit limit. In-order read responses pass
// straight through to the output stream; tlast marks the final line of each
// command. Status counters and a sticky no-metadata error are kept.

module copy_read_engine_split #(
    parameter int DATA_W              = 512,
    parameter int ADDR_W              = 48,
    parameter int LEN_W               = 16,
    parameter int MAX_BURST           = 16,
    parameter int MAX_LINES_IN_FLIGHT = 64,
    parameter int ID_W                = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              ar_valid,
    input  logic              ar_ready,
    output logic [ADDR_W-1:0] ar_addr,
    output logic [7:0]        ar_len,
    output logic [ID_W-1:0]   ar_id,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [DATA_W-1:0] r_data,
    input  logic              r_last,
    output logic              s_tvalid,
    input  logic              s_tready,
    output logic [DATA_W-1:0] s_tdata,
    output logic              s_tlast,
    output logic              busy,
    output logic [63:0]       num_lines_read,
    output logic [31:0]       num_cmds_done,
    output logic              err_no_meta
);

    localparam int BLEN_W = LEN_W + 1;
    localparam int OUT_W  = $clog2(MAX_LINES_IN_FLIGHT + 1);
    localparam int DEPTH  = MAX_LINES_IN_FLIGHT;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    // Lines in the next burst: limited by what is left of the command and by
    // the distance to the next MAX_BURST-aligned boundary.
    function automatic logic [BLEN_W-1:0] burst_len(input logic [ADDR_W-1:0] addr,
                                                    input logic [BLEN_W-1:0] rem);
        logic [ADDR_W-1:0] off;
        logic [BLEN_W-1:0] room;
        off  = addr & ADDR_W'(MAX_BURST - 1);
        room = BLEN_W'(MAX_BURST) - BLEN_W'(off);
        if (rem < room) begin
            burst_len = rem;
        end else begin
            burst_len = room;
        end
    endfunction

    // Advance a metadata FIFO pointer with wrap at DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = p + PTR_W'(1);
        end
    endfunction

    logic [0:0]        state_r;
    logic [0:0]        state_next_s;
    logic [ADDR_W-1:0] cur_addr_r;
    logic [BLEN_W-1:0] remaining_r;
    logic              cmd_ready_r;

    logic              ar_valid_r;
    logic [ADDR_W-1:0] ar_addr_r;
    logic [7:0]        ar_len_r;
    logic [ID_W-1:0]   ar_id_r;
    logic [OUT_W-1:0]  ar_blen_r;

    logic [OUT_W-1:0]  outstanding_r;
    logic [OUT_W-1:0]  out_next_s;

    logic [DEPTH-1:0]  meta_mem_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  meta_cnt_r;
    logic [CNT_W-1:0]  meta_cnt_next_s;

    logic              busy_r;
    logic [63:0]       lines_r;
    logic [31:0]       cmds_r;
    logic              err_r;

    logic              cmd_hs_s;
    logic              ar_hs_s;
    logic              r_hs_s;
    logic              meta_empty_s;
    logic              meta_push_s;
    logic              meta_pop_s;
    logic              out_dec_s;
    logic              last_burst_s;
    logic [BLEN_W-1:0] blen_s;
    logic [31:0]       need_s;
    logic              credit_ok_s;
    logic              load_ar_s;
    logic              tlast_s;

    // Handshakes, burst sizing and credit check for the next request.
    always_comb begin
        cmd_hs_s     = cmd_valid && cmd_ready_r;
        ar_hs_s      = ar_valid_r && ar_ready;
        r_hs_s       = r_valid && s_tready;
        meta_empty_s = (meta_cnt_r == CNT_W'(0));
        meta_push_s  = ar_hs_s;
        meta_pop_s   = r_hs_s && r_last && !meta_empty_s;
        out_dec_s    = r_hs_s && (outstanding_r != OUT_W'(0));
        last_burst_s = (remaining_r == BLEN_W'(ar_blen_r));
        blen_s       = burst_len(cur_addr_r, remaining_r);
        tlast_s      = r_valid && r_last && !meta_empty_s && meta_mem_r[rd_ptr_r];
        // Credits are checked against the post-update count so a burst can be
        // presented the cycle after the response that frees enough room.
        out_next_s   = outstanding_r;
        if (ar_hs_s && !out_dec_s) begin
            out_next_s = outstanding_r + ar_blen_r;
        end else if (ar_hs_s && out_dec_s) begin
            out_next_s = outstanding_r + ar_blen_r - OUT_W'(1);
        end else if (out_dec_s) begin
            out_next_s = outstanding_r - OUT_W'(1);
        end else begin
            out_next_s = outstanding_r;
        end
        need_s      = 32'(out_next_s) + 32'(blen_s);
        credit_ok_s = (need_s <= 32'(MAX_LINES_IN_FLIGHT));
        load_ar_s   = (state_r == ST_ISSUE) && !ar_valid_r && credit_ok_s;
        meta_cnt_next_s = meta_cnt_r;
        if (meta_push_s && !meta_pop_s) begin
            meta_cnt_next_s = meta_cnt_r + CNT_W'(1);
        end else if (!meta_push_s && meta_pop_s) begin
            meta_cnt_next_s = meta_cnt_r - CNT_W'(1);
        end else begin
            meta_cnt_next_s = meta_cnt_r;
        end
    end

    // Next-state decode: leave ISSUE once the final burst is accepted.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_hs_s) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (ar_hs_s && last_burst_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Command state: latch a new command and walk its address/remaining count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cur_addr_r  <= '0;
            remaining_r <= '0;
            cmd_ready_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cmd_ready_r <= (state_next_s == ST_IDLE);
            if (cmd_hs_s) begin
                cur_addr_r  <= cmd_addr;
                remaining_r <= BLEN_W'(cmd_len) + BLEN_W'(1);
            end else if (ar_hs_s) begin
                cur_addr_r  <= cur_addr_r + ADDR_W'(ar_blen_r);
                remaining_r <= remaining_r - BLEN_W'(ar_blen_r);
            end
        end
    end

    // Read address channel: fields are captured once and held until accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            ar_valid_r <= 1'b0;
            ar_addr_r  <= '0;
            ar_len_r   <= '0;
            ar_blen_r  <= '0;
            ar_id_r    <= '0;
        end else if (ar_hs_s) begin
            ar_valid_r <= 1'b0;
            ar_id_r    <= ar_id_r + ID_W'(1);
        end else if (load_ar_s) begin
            ar_valid_r <= 1'b1;
            ar_addr_r  <= cur_addr_r;
            ar_len_r   <= 8'(blen_s - BLEN_W'(1));
            ar_blen_r  <= OUT_W'(blen_s);
        end
    end

    // Lines-in-flight credit count.
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding_r <= '0;
        end else begin
            outstanding_r <= out_next_s;
        end
    end

    // Per-burst metadata FIFO holding the last-of-command flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_mem_r <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            meta_cnt_r <= '0;
        end else begin
            meta_cnt_r <= meta_cnt_next_s;
            if (meta_push_s) begin
                meta_mem_r[wr_ptr_r] <= last_burst_s;
                wr_ptr_r             <= ptr_inc(wr_ptr_r);
            end
            if (meta_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
        end
    end

    // Status: busy flag, delivery counters and sticky missing-metadata error.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r  <= 1'b0;
            lines_r <= '0;
            cmds_r  <= '0;
            err_r   <= 1'b0;
        end else begin
            busy_r <= (state_next_s == ST_ISSUE) || (out_next_s != OUT_W'(0)) ||
                      (meta_cnt_next_s != CNT_W'(0));
            if (r_hs_s) begin
                lines_r <= lines_r + 64'd1;
            end
            if (r_hs_s && tlast_s) begin
                cmds_r <= cmds_r + 32'd1;
            end
            if (r_hs_s && meta_empty_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign cmd_ready      = cmd_ready_r;
    assign ar_valid       = ar_valid_r;
    assign ar_addr        = ar_addr_r;
    assign ar_len         = ar_len_r;
    assign ar_id          = ar_id_r;
    assign r_ready        = s_tready;
    assign s_tvalid       = r_valid;
    assign s_tdata        = r_data;
    assign s_tlast        = tlast_s;
    assign busy           = busy_r;
    assign num_lines_read = lines_r;
    assign num_cmds_done  = cmds_r;
    assign err_no_meta    = err_r;

endmodule

// File: tb/tb_copy_read_engine_split.sv
// Directed self-checking bench for copy_read_engine_split (default parameters).
module tb_copy_read_engine_split;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [47:0]  cmd_addr;
    logic [15:0]  cmd_len;
    logic         ar_valid;
    logic         ar_ready;
    logic [47:0]  ar_addr;
    logic [7:0]   ar_len;
    logic [7:0]   ar_id;
    logic         r_valid;
    logic         r_ready;
    logic [511:0] r_data;
    logic         r_last;
    logic         s_tvalid;
    logic         s_tready;
    logic [511:0] s_tdata;
    logic         s_tlast;
    logic         busy;
    logic [63:0]  num_lines_read;
    logic [31:0]  num_cmds_done;
    logic         err_no_meta;

    int checks = 0;
    int errors = 0;

    copy_read_engine_split dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len), .ar_id(ar_id),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .busy(busy), .num_lines_read(num_lines_read), .num_cmds_done(num_cmds_done),
        .err_no_meta(err_no_meta)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] pat(input int n);
        pat = {16{32'(n) ^ 32'h5A5A_0000}};
    endfunction

    task automatic send_cmd(input logic [47:0] addr, input logic [15:0] len);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic expect_ar(input logic [47:0] addr, input logic [7:0] len, input logic [7:0] id);
        int n = 0;
        while (!ar_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ar_valid", ar_valid, 1);
        chk("ar_addr", ar_addr, addr);
        chk("ar_len", ar_len, len);
        chk("ar_id", ar_id, id);
        ar_ready = 1'b1;
        @(negedge clk);
        ar_ready = 1'b0;
    endtask

    task automatic send_beat(input logic [511:0] data, input logic last, input logic exp_tlast);
        r_valid = 1'b1;
        r_data  = data;
        r_last  = last;
        #1;
        chk("s_tvalid", s_tvalid, 1);
        chk("s_tdata", s_tdata, data);
        chk("s_tlast", s_tlast, exp_tlast);
        @(negedge clk);
        r_valid = 1'b0;
        r_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int idx;
        int cyc;
        logic hs;

        reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_last = 1'b0; s_tready = 1'b1;
        repeat (2) @(negedge clk);
        // Reset state
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_ar_valid", ar_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_lines", num_lines_read, 0);
        chk("rst_cmds", num_cmds_done, 0);
        chk("rst_err", err_no_meta, 0);
        chk("rst_r_ready", r_ready, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", cmd_ready, 1);

        // Single short command
        send_cmd(48'h100, 16'd3);
        expect_ar(48'h100, 8'd3, 8'd0);
        chk("t1_ready_again", cmd_ready, 1);
        for (int i = 0; i < 4; i++) send_beat(pat(i), i == 3, i == 3);
        chk("t1_lines", num_lines_read, 4);
        chk("t1_cmds", num_cmds_done, 1);
        chk("t1_busy", busy, 0);

        // Split / alignment
        reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
        send_cmd(48'h0C, 16'd39);
        expect_ar(48'h0C, 8'd3, 8'd0);
        expect_ar(48'h10, 8'd15, 8'd1);
        expect_ar(48'h20, 8'd15, 8'd2);
        expect_ar(48'h30, 8'd3, 8'd3);
        for (int i = 0; i < 40; i++)
            send_beat(pat(100 + i), (i == 3) || (i == 19) || (i == 35) || (i == 39), i == 39);
        chk("t2_lines", num_lines_read, 40);
        chk("t2_cmds", num_cmds_done, 1);

        // Credit stall: 128 aligned lines, only 64 may be in flight
        send_cmd(48'h200, 16'd127);
        expect_ar(48'h200, 8'd15, 8'd4);
        expect_ar(48'h210, 8'd15, 8'd5);
        expect_ar(48'h220, 8'd15, 8'd6);
        expect_ar(48'h230, 8'd15, 8'd7);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (ar_valid) cnt++;
            @(negedge clk);
        end
        chk("t3_stall", cnt, 0);
        for (int i = 0; i < 15; i++) send_beat(pat(300 + i), 1'b0, 1'b0);
        chk("t3_hold_at_49", ar_valid, 0);
        send_beat(pat(315), 1'b1, 1'b0);
        chk("t3_release", ar_valid, 1);
        expect_ar(48'h240, 8'd15, 8'd8);
        for (int b = 1; b < 4; b++) begin
            for (int i = 0; i < 16; i++) send_beat(pat(300 + 16 * b + i), i == 15, 1'b0);
            expect_ar(48'h240 + 48'(16 * b), 8'd15, 8'(8 + b));
        end

        // Backpressure: r_valid held, s_tready toggling, last 64 lines
        idx = 0;
        cyc = 0;
        while (idx < 64 && cyc < 400) begin
            s_tready = (cyc % 2 == 1);
            r_valid  = 1'b1;
            r_data   = pat(500 + idx);
            r_last   = (idx % 16 == 15);
            #1;
            chk("bp_r_ready", r_ready, s_tready);
            chk("bp_tdata", s_tdata, pat(500 + idx));
            chk("bp_tlast", s_tlast, idx == 63);
            hs = s_tready;
            @(negedge clk);
            if (hs) idx++;
            cyc++;
        end
        chk("bp_done", idx, 64);
        r_valid = 1'b0; r_last = 1'b0; s_tready = 1'b1;
        chk("t4_lines", num_lines_read, 168);
        chk("t4_cmds", num_cmds_done, 2);
        chk("t4_busy", busy, 0);

        // Back-to-back commands with a same-cycle AR handshake and r beat
        send_cmd(48'h400, 16'd15);
        expect_ar(48'h400, 8'd15, 8'd12);
        send_cmd(48'h410, 16'd7);
        cnt = 0;
        while (!ar_valid && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("t5_ar_valid", ar_valid, 1);
        chk("t5_ar_addr", ar_addr, 48'h410);
        chk("t5_ar_len", ar_len, 7);
        chk("t5_ar_id", ar_id, 12'd13);
        ar_ready = 1'b1;
        r_valid  = 1'b1;
        r_data   = pat(700);
        r_last   = 1'b0;
        #1;
        chk("t5_same_tlast", s_tlast, 0);
        @(negedge clk);
        ar_ready = 1'b0;
        for (int i = 1; i < 16; i++) send_beat(pat(700 + i), i == 15, i == 15);
        for (int i = 0; i < 7; i++) send_beat(pat(800 + i), 1'b0, 1'b0);
        chk("t5_busy_before", busy, 1);
        send_beat(pat(807), 1'b1, 1'b1);
        chk("t5_busy_after", busy, 0);
        chk("t5_lines", num_lines_read, 192);
        chk("t5_cmds", num_cmds_done, 4);

        // Reset mid-command, then an unsolicited beat
        send_cmd(48'h800, 16'd63);
        expect_ar(48'h800, 8'd15, 8'd14);
        expect_ar(48'h810, 8'd15, 8'd15);
        reset = 1'b1;
        s_tready = 1'b0;
        #1;
        chk("t6_r_ready_follow", r_ready, 0);
        s_tready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_lines", num_lines_read, 0);
        chk("t6_cmds", num_cmds_done, 0);
        chk("t6_ar_valid", ar_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_err", err_no_meta, 0);
        @(negedge clk);
        chk("t6_cmd_ready", cmd_ready, 1);
        chk("t6_ar_valid2", ar_valid, 0);
        send_beat(pat(900), 1'b1, 1'b0);
        chk("t6_err_set", err_no_meta, 1);
        chk("t6_lines_after", num_lines_read, 1);
        chk("t6_cmds_after", num_cmds_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
